// File: rtl/est_pkg.sv
// Shared constants and helpers for the sample-rate frequency estimator.
package est_pkg;

  localparam int unsigned EST_DATA_W = 32;
  localparam int unsigned EST_CNT_W  = 16;
  localparam int          EST_HYST   = 64;

  // Saturating increment for period counters of the default width
  function automatic logic [EST_CNT_W-1:0] sat_inc(input logic [EST_CNT_W-1:0] v);
    return (v == '1) ? v : v + EST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/moving_avg4.sv
// 4-tap moving average over strobed signed samples; one registered result per strobe.
module moving_avg4
  import est_pkg::*;
#(
  parameter int unsigned DATA_W = EST_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int unsigned SUM_W = DATA_W + 2;

  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [SUM_W-1:0]  sum_c;

  // Sign-extended sum of the new sample and the three previous ones
  always_comb begin
    sum_c = {{2{din[DATA_W-1]}}, din} + {{2{d0[DATA_W-1]}}, d0}
          + {{2{d1[DATA_W-1]}}, d1} + {{2{d2[DATA_W-1]}}, d2};
  end

  // Dropping the two LSBs of the sum is the arithmetic shift by two, truncated to DATA_W
  always_ff @(posedge clk) begin
    if (reset) begin
      d0         <= '0;
      d1         <= '0;
      d2         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= sum_c[DATA_W+1:2];
        d2   <= d1;
        d1   <= d0;
        d0   <= din;
      end
    end
  end

endmodule

// File: rtl/top_level.sv
// Frequency estimator: filtered signal, hysteresis comparator and rising-crossing period counter.
module top_level
  import est_pkg::*;
#(
  parameter int unsigned DATA_W = EST_DATA_W,
  parameter int unsigned CNT_W  = EST_CNT_W,
  parameter int          HYST   = EST_HYST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] entrada,
  input  logic              amostra_pronta,
  output logic              flag,
  output logic              ctrl,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;

  logic [DATA_W-1:0] x_filt;
  logic              v1;
  logic [CNT_W-1:0]  per_cnt;
  logic              armed;
  logic              above_c;
  logic              below_c;
  logic              rise_c;
  logic [CNT_W-1:0]  per_inc_c;

  moving_avg4 #(.DATA_W(DATA_W)) u_avg (
    .clk        (clk),
    .reset      (reset),
    .din        (entrada),
    .din_valid  (amostra_pronta),
    .dout       (x_filt),
    .dout_valid (v1)
  );

  // Hysteresis thresholds and saturating period increment
  always_comb begin
    above_c   = $signed(x_filt) > HYST_POS;
    below_c   = $signed(x_filt) < HYST_NEG;
    rise_c    = !ctrl && above_c;
    per_inc_c = (per_cnt == '1) ? per_cnt : per_cnt + CNT_W'(1);
  end

  // Comparator, period counter and reporting; the first rise only arms the measurement
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= 1'b0;
      cnt     <= '0;
      flag    <= 1'b0;
      per_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      flag <= 1'b0;
      if (v1) begin
        if (above_c) begin
          ctrl <= 1'b1;
        end else if (below_c) begin
          ctrl <= 1'b0;
        end
        if (rise_c) begin
          per_cnt <= '0;
          armed   <= 1'b1;
          if (armed) begin
            cnt  <= per_inc_c;
            flag <= 1'b1;
          end
        end else begin
          per_cnt <= per_inc_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: sample-level reference model feeding a scoreboard of expected periods.
module tb_top_level;
  import est_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        amostra_pronta;
  logic [31:0] entrada;
  logic        flag;
  logic        ctrl;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  top_level dut (
    .clk            (clk),
    .reset          (reset),
    .entrada        (entrada),
    .amostra_pronta (amostra_pronta),
    .flag           (flag),
    .ctrl           (ctrl),
    .cnt            (cnt)
  );

  typedef struct {
    longint din;
    logic   exp_ctrl;
  } vec_t;

  int          errors     = 0;
  int          checks     = 0;
  int          flag_count = 0;
  longint      exp_period = 0;
  logic [15:0] exp_q[$];

  longint      m_d0, m_d1, m_d2;
  bit          m_ctrl, m_armed;
  logic [15:0] m_per;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_d0 = 0; m_d1 = 0; m_d2 = 0;
    m_ctrl = 1'b0; m_armed = 1'b0; m_per = '0;
  endtask

  // Reference: filter, hysteresis and period bookkeeping per accepted sample
  task automatic model_sample(input longint v);
    longint filt;
    bit     rise;
    filt = (v + m_d0 + m_d1 + m_d2) >>> 2;
    m_d2 = m_d1; m_d1 = m_d0; m_d0 = v;
    rise = !m_ctrl && (filt > EST_HYST);
    if (filt > EST_HYST) m_ctrl = 1'b1;
    else if (filt < -EST_HYST) m_ctrl = 1'b0;
    if (rise) begin
      if (m_armed) exp_q.push_back(sat_inc(m_per));
      m_per   = '0;
      m_armed = 1'b1;
    end else begin
      m_per = sat_inc(m_per);
    end
  endtask

  // Called at a falling edge; returns gap falling edges later
  task automatic drive(input longint v, input int gap);
    entrada        = 32'(v);
    amostra_pronta = 1'b1;
    model_sample(v);
    @(negedge clk);
    amostra_pronta = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    amostra_pronta = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check(name, longint'(exp_q.size()), 0);
  endtask

  function automatic longint sine(input int n);
    return longint'($rtoi(1000.0 * $sin(6.283185307179586 * real'(n + 10) / 20.0)));
  endfunction

  // Scoreboard: every flag must match the next queued period
  always @(negedge clk) begin
    if (reset === 1'b0 && flag === 1'b1) begin
      flag_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_flag", longint'(cnt), -1);
      end else begin
        check("cnt_vs_model", longint'(cnt), longint'(exp_q.pop_front()));
      end
      if (exp_period != 0) check("cnt_vs_period", longint'(cnt), exp_period);
    end
  end

  vec_t tbl[24];
  int   fc0;
  int   fc1;

  initial begin
    // Step and hysteresis boundaries; floor rounding of the >>>2 matters at -65
    tbl[0]  = '{-1000, 1'b0}; tbl[1]  = '{-1000, 1'b0}; tbl[2]  = '{-1000, 1'b0};
    tbl[3]  = '{-1000, 1'b0}; tbl[4]  = '{1000, 1'b0};  tbl[5]  = '{1000, 1'b0};
    tbl[6]  = '{1000, 1'b1};  tbl[7]  = '{1000, 1'b1};  tbl[8]  = '{-64, 1'b1};
    tbl[9]  = '{-64, 1'b1};   tbl[10] = '{-64, 1'b1};   tbl[11] = '{-64, 1'b1};
    tbl[12] = '{-65, 1'b0};   tbl[13] = '{-65, 1'b0};   tbl[14] = '{-65, 1'b0};
    tbl[15] = '{-65, 1'b0};   tbl[16] = '{64, 1'b0};    tbl[17] = '{64, 1'b0};
    tbl[18] = '{64, 1'b0};    tbl[19] = '{64, 1'b0};    tbl[20] = '{65, 1'b0};
    tbl[21] = '{65, 1'b0};    tbl[22] = '{65, 1'b0};    tbl[23] = '{65, 1'b1};

    reset          = 1'b1;
    amostra_pronta = 1'b0;
    entrada        = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_flag", longint'(flag), 0);
    check("reset_ctrl", longint'(ctrl), 0);
    check("reset_cnt", longint'(cnt), 0);

    // Step table: arm on the +1000 ramp, report 17 samples later on the 65 ramp
    exp_period = 17;
    fc0 = flag_count;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].din, 3);
      check($sformatf("step_ctrl[%0d]", i), longint'(ctrl), longint'(tbl[i].exp_ctrl));
    end
    drain("step_drain");
    check("step_flags", longint'(flag_count - fc0), 1);

    // Sine, period 20, strobe every 16 clocks
    do_reset();
    exp_period = 20;
    fc0 = flag_count;
    for (int n = 0; n < 120; n++) drive(sine(n), 16);
    drain("sine_drain");
    check("sine_flags", longint'(flag_count - fc0), 5);

    // Square +-500, period 50, strobe every cycle
    do_reset();
    exp_period = 50;
    fc0 = flag_count;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 50; k++) drive((k < 25) ? -500 : 500, 1);
    drain("square_drain");
    check("square_flags", longint'(flag_count - fc0), 3);

    // Zero, then noise within the hysteresis band
    do_reset();
    exp_period = 0;
    fc0 = flag_count;
    for (int k = 0; k < 50; k++) drive(0, 1);
    for (int k = 0; k < 200; k++) drive(longint'(int'($urandom_range(128)) - 64), 2);
    check("noise_ctrl", longint'(ctrl), 0);
    drain("noise_drain");
    check("noise_flags", longint'(flag_count - fc0), 0);

    // Reset mid-period, with a strobe held during reset that must be ignored
    do_reset();
    exp_period = 20;
    fc0 = flag_count;
    for (int n = 0; n < 41; n++) drive(sine(n), 4);
    check("pre_reset_ctrl", longint'(ctrl), 1);
    reset          = 1'b1;
    amostra_pronta = 1'b1;
    entrada        = 32'd5000;
    repeat (2) @(negedge clk);
    check("midreset_flag", longint'(flag), 0);
    check("midreset_ctrl", longint'(ctrl), 0);
    check("midreset_cnt", longint'(cnt), 0);
    reset          = 1'b0;
    amostra_pronta = 1'b0;
    model_reset();
    exp_q.delete();
    fc1 = flag_count;
    for (int n = 0; n < 20; n++) drive(sine(n), 4);
    check("rearm_no_flag", longint'(flag_count - fc1), 0);
    check("rearm_cnt_held", longint'(cnt), 0);
    for (int n = 20; n < 70; n++) drive(sine(n), 4);
    drain("reset_drain");
    check("reset_flags", longint'(flag_count - fc0), 3);

    // Saturation: arm, then 70000 samples of DC before the next rise
    do_reset();
    exp_period = 64'hFFFF;
    fc0 = flag_count;
    repeat (4) drive(-500, 1);
    repeat (4) drive(500, 1);
    repeat (70000) drive(-500, 1);
    repeat (4) drive(500, 1);
    drain("sat_drain");
    check("sat_flags", longint'(flag_count - fc0), 1);
    check("sat_cnt_held", longint'(cnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
